// File: rtl/bram_port_arbiter_if.sv
// Bundle of both requester ports and the shared RAM port seen by bram_port_arbiter.
// The arbiter uses the slave view; requesters plus the RAM attach through the master view.
interface bram_port_arbiter_if #(
  parameter int unsigned DATA = 72,
  parameter int unsigned ADDR = 10
);
  logic            r0_req;
  logic            r0_wr;
  logic            r0_lock;
  logic [ADDR-1:0] r0_addr;
  logic [DATA-1:0] r0_din;
  logic            r0_gnt;
  logic            r0_rvalid;
  logic [DATA-1:0] r0_rdata;

  logic            r1_req;
  logic            r1_wr;
  logic            r1_lock;
  logic [ADDR-1:0] r1_addr;
  logic [DATA-1:0] r1_din;
  logic            r1_gnt;
  logic            r1_rvalid;
  logic [DATA-1:0] r1_rdata;

  logic            m_wr;
  logic [ADDR-1:0] m_addr;
  logic [DATA-1:0] m_din;
  logic [DATA-1:0] m_dout;

  modport slave (
    input  r0_req, r0_wr, r0_lock, r0_addr, r0_din,
    output r0_gnt, r0_rvalid, r0_rdata,
    input  r1_req, r1_wr, r1_lock, r1_addr, r1_din,
    output r1_gnt, r1_rvalid, r1_rdata,
    output m_wr, m_addr, m_din,
    input  m_dout
  );

  modport master (
    output r0_req, r0_wr, r0_lock, r0_addr, r0_din,
    input  r0_gnt, r0_rvalid, r0_rdata,
    output r1_req, r1_wr, r1_lock, r1_addr, r1_din,
    input  r1_gnt, r1_rvalid, r1_rdata,
    input  m_wr, m_addr, m_din,
    output m_dout
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one block-RAM port between two requesters, with an
// optional lock for read-modify-write sequences and tagged one-cycle read return.
module bram_port_arbiter #(
  parameter int unsigned DATA = 72,
  parameter int unsigned ADDR = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  bram_port_arbiter_if.slave   bus
);

  logic [1:0]      req;
  logic [1:0]      wr;
  logic [1:0]      lock;
  logic [ADDR-1:0] addr [2];
  logic [DATA-1:0] din  [2];

  logic [1:0]      gnt;
  logic            held;
  logic            xfer;
  logic            win;

  logic            last;
  logic            locked;
  logic            owner;
  logic [ADDR-1:0] addr_q;
  logic [1:0]      rvalid_q;

  assign req     = {bus.r1_req,  bus.r0_req};
  assign wr      = {bus.r1_wr,   bus.r0_wr};
  assign lock    = {bus.r1_lock, bus.r0_lock};
  assign addr[0] = bus.r0_addr;
  assign addr[1] = bus.r1_addr;
  assign din[0]  = bus.r0_din;
  assign din[1]  = bus.r1_din;

  // An owner with neither req nor lock releases the port in the same cycle,
  // so the lock only holds while the owner still asks for it.
  always_comb begin
    held = locked && (req[owner] || lock[owner]);
    gnt  = '0;
    if (!rst) begin
      if (held)
        gnt[owner] = req[owner];
      else if (&req)
        gnt[~last] = 1'b1;
      else
        gnt = req;
    end
    xfer = |gnt;
    win  = gnt[1];
  end

  assign bus.r0_gnt = gnt[0];
  assign bus.r1_gnt = gnt[1];

  assign bus.m_wr   = xfer & wr[win];
  assign bus.m_addr = xfer ? addr[win] : addr_q;
  assign bus.m_din  = din[win];

  // Gated by rst so a read accepted just before reset never returns.
  assign bus.r0_rvalid = rvalid_q[0] & ~rst;
  assign bus.r1_rvalid = rvalid_q[1] & ~rst;
  assign bus.r0_rdata  = bus.r0_rvalid ? bus.m_dout : '0;
  assign bus.r1_rdata  = bus.r1_rvalid ? bus.m_dout : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      last     <= 1'b1;
      locked   <= 1'b0;
      owner    <= 1'b0;
      addr_q   <= '0;
      rvalid_q <= '0;
    end else begin
      rvalid_q <= gnt & ~wr;
      if (xfer) begin
        last   <= win;
        addr_q <= addr[win];
        locked <= lock[win];
        if (lock[win])
          owner <= win;
      end else if (!held) begin
        locked <= 1'b0;
      end
    end
  end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Single-clock arbiter that shares one port of the dual-port block RAM between two requesters. It performs round-robin arbitration with a per-access valid/grant handshake and returns read data tagged to the requester that issued the read. It also provides an optional lock that holds the port for one requester across a multi-beat read-modify-write sequence. It sits between two client engines and port A or port B of the block RAM.

## Interface
- DATA, 72, word width; must match the RAM.
- ADDR, 10, address width; must match the RAM.

- clk  in  1  clock for all logic; the RAM port clock is tied to this clock.
- rst  in  1  reset, synchronous and active-high.
- r0_req  in  1  requester 0 access request.
- r0_wr  in  1  requester 0 access type: 1 = write, 0 = read.
- r0_lock  in  1  requester 0 request to hold the port after this access.
- r0_addr  in  ADDR  requester 0 address.
- r0_din  in  DATA  requester 0 write data.
- r0_gnt  out  1  requester 0 access accepted this cycle.
- r0_rvalid  out  1  requester 0 read data valid.
- r0_rdata  out  DATA  requester 0 read data.
- r1_req, r1_wr, r1_lock, r1_addr, r1_din, r1_gnt, r1_rvalid, r1_rdata: same as requester 0, for requester 1.
- m_wr  out  1  RAM port write enable.
- m_addr  out  ADDR  RAM port address.
- m_din  out  DATA  RAM port write data.
- m_dout  in  DATA  RAM port read data, registered inside the RAM with one cycle of latency.

## Operation
- **Handshake**
  - An access transfers in a cycle where rN_req=1 and rN_gnt=1.
  - Requesters hold wr, addr, din and lock stable while rN_req=1 and rN_gnt=0.
  - At most one rN_gnt is high per cycle.
  - rN_gnt is combinational from the req inputs and registered state; it never depends on rN_gnt of the other requester.
- **Arbitration**
  - Register `last` holds the most recent winner.
  - Only one requester asserts req: it wins.
  - Both assert req: the requester that is not `last` wins.
  - `last` updates to the winner on every transfer.
- **Lock**
  - Registers `locked` and `owner`.
  - Setting the lock: a transfer with rN_lock=1 sets locked=1 and owner=N.
  - While locked=1, only owner can be granted. The other requester's gnt is 0 even if the owner is idle.
  - Releasing the lock: locked clears on the owner's transfer with rN_lock=0. It also clears in any cycle where the owner has rN_req=0 and rN_lock=0. In that cycle the non-owner is eligible for grant.
- **RAM drive**
  - m_wr = winner's wr and transfer; m_addr and m_din = winner's inputs.
  - With no transfer: m_wr=0, and m_addr holds the previous value (registered copy).
- **Read return**
  - A read transfer in cycle k sets rN_rvalid=1 in cycle k+1, for exactly one cycle.
  - rN_rdata = m_dout (combinational passthrough) while rN_rvalid=1.
  - rN_rdata is 0 when rN_rvalid=0.
  - Writes produce no rvalid.
- **Back-to-back accesses**
  - Transfers may occur every cycle with no bubbles.
  - Consecutive rvalids may belong to different requesters.

## Timing
- **Reset values** (on the clock edge with rst=1):
  - r0_gnt=r1_gnt=0 and m_wr=0 while rst is high.
  - rvalid=0, rdata=0, locked=0, owner=0, m_addr=0.
  - last=1, so requester 0 wins the first contention.
- **Reset mid-operation**
  - A read accepted in the cycle before reset does not produce rvalid after reset.
  - No RAM write is issued while rst=1.
- **Latency**
  - Grant: 0 cycles, combinational within the request cycle.
  - Read data: 1 cycle after transfer.
  - Write: visible to a read transferred in the next cycle.
- **Write-first read-back**: a read following a write to the same address in consecutive cycles returns the new data.
- **Lock timing**: lock set and clear take effect from the cycle after the transfer, except the idle-release rule, which is combinational.
- **Width**: addresses are passed unmodified, with no wrap or offset arithmetic.

## Test plan
- **Reset and idle**: hold rst 3 cycles with both req=1.
  - Both gnt=0, m_wr=0, rvalid=0 throughout.
  - The first cycle after release grants requester 0.
- **Contention**: both read continuously for 6 cycles, addresses 0x010 (requester 0) and 0x020 (requester 1).
  - Grants alternate 0,1,0,1,0,1.
  - rvalid alternates one cycle later.
  - rdata equals RAM contents at those addresses.
- **Write then read**: requester 1 writes 0xA5 to 0x3FF, then reads 0x3FF in the next cycle.
  - r1_rvalid=1 with r1_rdata=0xA5 two cycles after the write.
- **Lock hold**: requester 0 reads 0x005 with lock=1, idles 2 cycles with lock=1, then writes with lock=0. Requester 1 requests throughout.
  - r1_gnt=0 until the cycle after requester 0's unlocked write.
- **Idle release**: the lock owner drops both req and lock.
  - The waiting requester is granted in that same cycle.
- **Reset mid-read**: assert rst in the cycle after a read transfer.
  - rvalid stays 0, and the following grant goes to requester 0.
